// File: rtl/rtc_scan_display.sv
// Real-time clock (hh:mm:ss) with a multiplexed six-digit seven-segment display.
// Define RTC_TIME_SET_EN to add the set_load / set_hours / set_minutes time-load port.
module rtc_scan_display #(
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_DIV       = 8192,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_toggle,
  input  logic       clear,
  input  logic       mode_12h,
`ifdef RTC_TIME_SET_EN
  input  logic       set_load,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
`endif
  output logic [7:0] seg,
  output logic [5:0] digit_sel,
  output logic       tick_1hz,
  output logic       running
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
  localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [5:0]    sec, min;
  logic [4:0]    hr;
  logic [SW-1:0] scan;
  logic [2:0]    dig;
  logic [4:0]    hr_disp;
  logic [3:0]    digit;
  logic          blank, dp, colon;
  logic [7:0]    seg_raw;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] pol_seg(input logic [7:0] s);
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  function automatic logic [5:0] pol_sel(input logic [5:0] s);
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

`ifdef RTC_TIME_SET_EN
  logic set_ok;
  assign set_ok = set_load && (set_hours <= 5'd23) && (set_minutes <= 6'd59);
`endif

  // Timekeeping stage: prescaler, h:m:s counters, run state, tick pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc    <= '0;
      sec      <= '0;
      min      <= '0;
      hr       <= '0;
      running  <= 1'b0;
      tick_1hz <= 1'b0;
    end else begin
      tick_1hz <= 1'b0;
      if (run_toggle) running <= ~running;
      if (clear) begin
        presc <= '0;
        sec   <= '0;
        min   <= '0;
        hr    <= '0;
      end
`ifdef RTC_TIME_SET_EN
      else if (set_ok) begin
        presc <= '0;
        sec   <= '0;
        min   <= set_minutes;
        hr    <= set_hours;
      end
`endif
      else if (running) begin
        if (presc == PRESC_MAX) begin
          presc    <= '0;
          tick_1hz <= 1'b1;
          if (sec == 6'd59) begin
            sec <= '0;
            if (min == 6'd59) begin
              min <= '0;
              hr  <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
            end else begin
              min <= min + 6'd1;
            end
          end else begin
            sec <= sec + 6'd1;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  // Colon stays lit whenever the clock is stopped so a frozen display is obvious
  assign colon = !running || (presc < PRESC_HALF);

  always_comb begin
    hr_disp = hr;
    if (mode_12h) begin
      if (hr == 5'd0)       hr_disp = 5'd12;
      else if (hr > 5'd12)  hr_disp = hr - 5'd12;
    end
    digit = '0;
    blank = 1'b0;
    dp    = 1'b0;
    case (dig)
      3'd0: begin digit = 4'(sec % 6'd10); dp = mode_12h && (hr >= 5'd12); end
      3'd1: digit = 4'(sec / 6'd10);
      3'd2: begin digit = 4'(min % 6'd10); dp = colon; end
      3'd3: digit = 4'(min / 6'd10);
      3'd4: begin digit = 4'(hr_disp % 5'd10); dp = colon; end
      3'd5: begin digit = 4'(hr_disp / 5'd10); blank = mode_12h && (hr_disp < 5'd10); end
      default: blank = 1'b1;
    endcase
    seg_raw = {dp, blank ? 7'h00 : glyph(digit)};
  end

  // Scan stage: digit index and registered outputs share one edge so segments never lag the select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan      <= '0;
      dig       <= '0;
      seg       <= pol_seg(8'h00);
      digit_sel <= pol_sel(6'h00);
    end else begin
      if (scan == SCAN_MAX) begin
        scan <= '0;
        dig  <= (dig == 3'd5) ? 3'd0 : dig + 3'd1;
      end else begin
        scan <= scan + SW'(1);
      end
      seg       <= pol_seg(seg_raw);
      digit_sel <= pol_sel(6'b000001 << dig);
    end
  end

endmodule

// File: tb/tb_rtc_scan_display.sv
// Bench for rtc_scan_display: seconds-of-day reference model checked every cycle,
// a glyph table for fixed times, directed corner sequences and random stimulus.
module tb_rtc_scan_display;
  localparam int CLK_HZ   = 10;
  localparam int SCAN_DIV = 4;
  localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0, rst = 1'b1, run_toggle = 1'b0, clear = 1'b0, mode_12h = 1'b0;
`ifdef RTC_TIME_SET_EN
  logic       set_load = 1'b0;
  logic [4:0] set_hours = '0;
  logic [5:0] set_minutes = '0;
`endif
  logic [7:0] seg;
  logic [5:0] digit_sel;
  logic       tick_1hz, running;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rtc_scan_display #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .run_toggle(run_toggle), .clear(clear), .mode_12h(mode_12h),
`ifdef RTC_TIME_SET_EN
    .set_load(set_load), .set_hours(set_hours), .set_minutes(set_minutes),
`endif
    .seg(seg), .digit_sel(digit_sel), .tick_1hz(tick_1hz), .running(running));

  // Reference model: time as seconds of day, display from digit arithmetic
  int m_tsec, m_presc, m_cyc, m_idx, seen_seq;
  int req_tsec = 0, req_seq = 0;
  bit m_run, nxt_run;
  logic [7:0] e_seg;
  logic [5:0] e_sel;
  bit e_tick;

  function automatic logic [7:0] exp_digit(int idx, int tsec, bit m12, bit colon);
    int h, m, s, dh, d;
    bit blank, dp;
    h = tsec / 3600; m = (tsec / 60) % 60; s = tsec % 60;
    dh = m12 ? (((h % 12) == 0) ? 12 : h % 12) : h;
    blank = 1'b0; dp = 1'b0;
    case (idx)
      0: begin d = s % 10; dp = m12 && (h >= 12); end
      1: d = s / 10;
      2: begin d = m % 10; dp = colon; end
      3: d = m / 10;
      4: begin d = dh % 10; dp = colon; end
      default: begin d = dh / 10; blank = m12 && (dh < 10); end
    endcase
    return ~{dp, blank ? 7'h00 : GLYPH[d]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tsec = 0; m_presc = 0; m_run = 1'b0; m_cyc = 0;
      e_seg = 8'hFF; e_sel = 6'h3F; e_tick = 1'b0;
      seen_seq = req_seq;
    end else begin
      if (seen_seq != req_seq) begin m_tsec = req_tsec; seen_seq = req_seq; end
      m_idx = (m_cyc / SCAN_DIV) % 6;
      e_seg = exp_digit(m_idx, m_tsec, mode_12h, !m_run || (m_presc < CLK_HZ / 2));
      e_sel = ~(6'b000001 << m_idx);
      nxt_run = run_toggle ? !m_run : m_run;
`ifdef RTC_TIME_SET_EN
      e_tick = m_run && (m_presc == CLK_HZ - 1) && !clear &&
               !(set_load && set_hours <= 23 && set_minutes <= 59);
      if (clear) begin m_tsec = 0; m_presc = 0; end
      else if (set_load && set_hours <= 23 && set_minutes <= 59) begin
        m_tsec = int'(set_hours) * 3600 + int'(set_minutes) * 60; m_presc = 0;
      end
`else
      e_tick = m_run && (m_presc == CLK_HZ - 1) && !clear;
      if (clear) begin m_tsec = 0; m_presc = 0; end
`endif
      else if (m_run) begin
        if (m_presc == CLK_HZ - 1) begin m_presc = 0; m_tsec = (m_tsec + 1) % 86400; end
        else m_presc++;
      end
      m_run = nxt_run;
      m_cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_en)
      check("cycle", {16'h0, seg, digit_sel, tick_1hz, running}, {16'h0, e_seg, e_sel, e_tick, m_run});
  endtask

  task automatic pulse_run();
    run_toggle = 1'b1; step(); run_toggle = 1'b0;
  endtask

  task automatic wait_presc_max();
    for (int k = 0; k < 20 && m_presc != CLK_HZ - 1; k++) step();
    if (m_presc != CLK_HZ - 1) check("presc_wait_timeout", 32'd0, 32'd1);
  endtask

  logic [4:0] f_hr;
  logic [5:0] f_min, f_sec;
  task set_time(input int h, input int m, input int s);
    f_hr = 5'(h); f_min = 6'(m); f_sec = 6'(s);
    force dut.hr = f_hr; force dut.min = f_min; force dut.sec = f_sec;
    req_tsec = h * 3600 + m * 60 + s; req_seq++;
    step();
    release dut.hr; release dut.min; release dut.sec;
  endtask

  typedef struct { int h; int m; int s; bit m12; int idx; logic [7:0] seg; } vec_t;
  vec_t tbl [17];

  initial begin
    int ticks, last_i, changes, k;
    logic [5:0] prev;
    tbl[0]  = '{12, 34, 56, 1'b0, 0, 8'h82};
    tbl[1]  = '{12, 34, 56, 1'b0, 1, 8'h92};
    tbl[2]  = '{12, 34, 56, 1'b0, 2, 8'h19};
    tbl[3]  = '{12, 34, 56, 1'b0, 3, 8'hB0};
    tbl[4]  = '{12, 34, 56, 1'b0, 4, 8'h24};
    tbl[5]  = '{12, 34, 56, 1'b0, 5, 8'hF9};
    tbl[6]  = '{13,  0,  0, 1'b1, 4, 8'h79};
    tbl[7]  = '{13,  0,  0, 1'b1, 5, 8'hFF};
    tbl[8]  = '{13,  0,  0, 1'b1, 0, 8'h40};
    tbl[9]  = '{13,  0,  0, 1'b0, 4, 8'h30};
    tbl[10] = '{13,  0,  0, 1'b0, 5, 8'hF9};
    tbl[11] = '{ 0,  0,  0, 1'b1, 5, 8'hF9};
    tbl[12] = '{ 0,  0,  0, 1'b1, 4, 8'h24};
    tbl[13] = '{ 0,  0,  0, 1'b1, 0, 8'hC0};
    tbl[14] = '{ 9,  5,  0, 1'b1, 5, 8'hFF};
    tbl[15] = '{ 9,  5,  0, 1'b0, 5, 8'hC0};
    tbl[16] = '{12,  0,  0, 1'b1, 0, 8'h40};

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_seg", seg, 8'hFF);
    check("rst_sel", digit_sel, 6'h3F);
    check("rst_tick", tick_1hz, 1'b0);
    check("rst_run", running, 1'b0);
    @(negedge clk); @(negedge clk);
    check("rst_hold_seg", seg, 8'hFF);
    rst = 1'b1;
    chk_en = 1'b1;
    step();
    check("first_sel", digit_sel, 6'h3E);
    check("first_seg", seg, 8'hC0);

    // Ten ticks at 10-cycle spacing
    pulse_run();
    ticks = 0; last_i = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (tick_1hz) begin
        if (last_i >= 0) check("tick_spacing", i - last_i, 10);
        last_i = i; ticks++;
      end
    end
    check("tick_count", ticks, 10);
    check("time_10s", {dut.hr, dut.min, dut.sec}, {5'd0, 6'd0, 6'd10});

    // Clear on the prescaler's terminal count
    wait_presc_max();
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_time", {dut.hr, dut.min, dut.sec}, 17'd0);
    check("clear_run", running, 1'b1);
    check("clear_tick", tick_1hz, 1'b0);
    step();
    check("clear_tick_after", tick_1hz, 1'b0);

    // Reset just before a tick would fire
    wait_presc_max();
    rst = 1'b0;
    #1;
    check("midrst_seg", seg, 8'hFF);
    check("midrst_sel", digit_sel, 6'h3F);
    check("midrst_run", running, 1'b0);
    check("midrst_tick", tick_1hz, 1'b0);
    step();
    rst = 1'b1;
    step(); step();
    check("postrst_tick", tick_1hz, 1'b0);
    check("postrst_sel", digit_sel, 6'h3E);

    // Day rollover
    set_time(23, 59, 59);
    pulse_run();
    ticks = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (tick_1hz) ticks++;
    end
    check("rollover_ticks", ticks, 1);
    check("rollover_time", {dut.hr, dut.min, dut.sec}, 17'd0);
    pulse_run();

    // Scan rotation over 24 digit periods
    set_time(12, 34, 56);
    prev = digit_sel; changes = 0;
    for (int i = 0; i < 96; i++) begin
      step();
      if (digit_sel != prev) begin
        check("scan_rot", digit_sel, {prev[4:0], prev[5]});
        prev = digit_sel; changes++;
      end
    end
    check("scan_changes", changes, 24);

    // Glyph table at fixed times
    foreach (tbl[n]) begin
      mode_12h = tbl[n].m12;
      set_time(tbl[n].h, tbl[n].m, tbl[n].s);
      step(); step();
      k = 0;
      while (k < 30 && digit_sel != ~(6'b000001 << tbl[n].idx)) begin step(); k++; end
      if (k >= 30) check("glyph_wait_timeout", 32'd0, 32'd1);
      else check($sformatf("glyph_%0d", n), seg, tbl[n].seg);
    end

`ifdef RTC_TIME_SET_EN
    set_time(5, 6, 7);
    set_hours = 5'd24; set_minutes = 6'd0; set_load = 1'b1; step(); set_load = 1'b0;
    check("set_bad_ignored", {dut.hr, dut.min, dut.sec}, {5'd5, 6'd6, 6'd7});
    set_hours = 5'd7; set_minutes = 6'd45; set_load = 1'b1; clear = 1'b1; step();
    set_load = 1'b0; clear = 1'b0;
    check("set_clear_wins", {dut.hr, dut.min, dut.sec}, 17'd0);
    set_load = 1'b1; step(); set_load = 1'b0;
    check("set_ok", {dut.hr, dut.min, dut.sec}, {5'd7, 6'd45, 6'd0});
`endif

    // Randomized run/clear/mode activity, checked every cycle by the model
    mode_12h = 1'b1;
    set_time(11, 59, 50);
    pulse_run();
    for (int i = 0; i < 400; i++) begin
      run_toggle = ($urandom_range(0, 15) == 0);
      clear      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 63) == 0) mode_12h = ~mode_12h;
      step();
    end
    run_toggle = 1'b0; clear = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
